fetch_unit: RTL and testbench

//  Program counter / instruction-fetch stage feeding the control decoder.

---
 rtl/fetch_unit_if.sv | 59 +++++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Handshake/bus bundle between the fetch stage, the
//                instruction ROM and the downstream decoder. The LUT write
//                port exists only when BRANCH_LUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int LUT_DEPTH = 16
);
    localparam int c_LUT_AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

    logic               Start;
    logic               Stall;
    logic               Branch_en;
    logic [PC_W-1:0]    Branch_target;
    logic               Halt_req;
    logic [PC_W-1:0]    Imem_addr;
    logic [INSTR_W-1:0] Imem_data;
    logic [INSTR_W-1:0] Instruction;
    logic               Instr_valid;
    logic [PC_W-1:0]    PC;
    logic               Done;
`ifdef BRANCH_LUT_EN
    logic               Lut_we;
    logic [c_LUT_AW-1:0] Lut_waddr;
    logic [PC_W-1:0]    Lut_wdata;

    // Environment side: decoder, sequencer and ROM
    modport master (
        output Start, Stall, Branch_en, Branch_target, Halt_req, Imem_data,
               Lut_we, Lut_waddr, Lut_wdata,
        input  Imem_addr, Instruction, Instr_valid, PC, Done
    );

    // Fetch unit side
    modport slave (
        input  Start, Stall, Branch_en, Branch_target, Halt_req, Imem_data,
               Lut_we, Lut_waddr, Lut_wdata,
        output Imem_addr, Instruction, Instr_valid, PC, Done
    );
`else
    // Environment side: decoder, sequencer and ROM
    modport master (
        output Start, Stall, Branch_en, Branch_target, Halt_req, Imem_data,
        input  Imem_addr, Instruction, Instr_valid, PC, Done
    );

    // Fetch unit side
    modport slave (
        input  Start, Stall, Branch_en, Branch_target, Halt_req, Imem_data,
        output Imem_addr, Instruction, Instr_valid, PC, Done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Program counter / instruction-fetch stage. Drives a
//                synchronous-read instruction ROM, presents one instruction
//                with its PC to the decoder, and handles start/halt
//                sequencing, stall hold and one-bubble branch squash.
//                Optional macro BRANCH_LUT_EN: branch targets come from a
//                reset-cleared, writable target LUT indexed by the low bits
//                of Branch_target.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int PC_W       = 10,
    parameter int INSTR_W    = 9,
    parameter int START_ADDR = 0,
    parameter int LUT_DEPTH  = 16
) (
    input  wire logic   Clk,
    input  wire logic   Reset,
    fetch_unit_if.slave bus
);

    localparam int              c_LUT_AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    localparam logic [PC_W-1:0] c_START  = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0] c_ONE    = PC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_fpc;          // address currently on the ROM
    logic [PC_W-1:0]    w_fpc_nxt;
    logic [PC_W-1:0]    r_pc;           // address of the word now on Imem_data
    logic [PC_W-1:0]    w_pc_nxt;
    logic               r_squash;       // current word is the wrong-path fetch
    logic               w_squash_nxt;
    logic               r_hold;         // stall in progress, word captured
    logic [INSTR_W-1:0] r_hold_data;
    logic               w_valid;
    logic               w_take_halt;
    logic               w_take_branch;
    logic [PC_W-1:0]    w_target;

`ifdef BRANCH_LUT_EN
    logic [PC_W-1:0]    r_lut [LUT_DEPTH];
    logic               w_unused;

    // Target LUT: written by the environment, cleared on reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
        end else if (bus.Lut_we) begin
            r_lut[bus.Lut_waddr] <= bus.Lut_wdata;
        end
    end

    // Read sees the pre-write contents, so a same-cycle write is not visible
    assign w_target = r_lut[bus.Branch_target[c_LUT_AW-1:0]];
    // Only the index bits of Branch_target matter here
    assign w_unused = &{1'b0, bus.Branch_target};
`else
    assign w_target = bus.Branch_target;
`endif

    // The ROM keeps reading FPC during a stall, so its data moves on;
    // the word under decode is captured on the first stalled cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hold      <= 1'b0;
            r_hold_data <= '0;
        end else if ((r_state == S_RUN) && bus.Stall) begin
            if (!r_hold) begin
                r_hold      <= 1'b1;
                r_hold_data <= bus.Imem_data;
            end
        end else begin
            r_hold <= 1'b0;
        end
    end

    assign w_valid         = (r_state == S_RUN) && !r_squash;
    assign bus.Instr_valid = w_valid;
    assign bus.Instruction = w_valid ? (r_hold ? r_hold_data : bus.Imem_data) : '0;
    assign bus.Imem_addr   = r_fpc;
    assign bus.PC          = r_pc;
    assign bus.Done        = (r_state == S_HALT);

    // Halt has priority over a branch in the same cycle
    assign w_take_halt   = w_valid && !bus.Stall && bus.Halt_req;
    assign w_take_branch = w_valid && !bus.Stall && bus.Branch_en && !bus.Halt_req;

    // State and fetch-pointer registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_fpc    <= c_START;
            r_pc     <= c_START;
            r_squash <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_fpc    <= w_fpc_nxt;
            r_pc     <= w_pc_nxt;
            r_squash <= w_squash_nxt;
        end
    end

    // Next-state and fetch-pointer sequencing
    always_comb begin
        w_state_nxt  = r_state;
        w_fpc_nxt    = r_fpc;
        w_pc_nxt     = r_pc;
        w_squash_nxt = r_squash;
        case (r_state)
            S_IDLE: begin
                w_fpc_nxt    = c_START;
                w_pc_nxt     = c_START;
                w_squash_nxt = 1'b0;
                if (bus.Start) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (!bus.Stall) begin
                    w_pc_nxt     = r_fpc;
                    w_fpc_nxt    = r_fpc + c_ONE;
                    w_squash_nxt = 1'b0;
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.Stall) begin
                    if (w_take_halt) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pc_nxt     = r_fpc;
                        w_fpc_nxt    = w_take_branch ? w_target : (r_fpc + c_ONE);
                        w_squash_nxt = w_take_branch;
                    end
                end
            end
            S_HALT: begin
                if (bus.Start) begin
                    w_fpc_nxt   = c_START;
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Randomised scoreboard bench for fetch_unit. A word-stream
//                reference model predicts which (cycle, PC, instruction)
//                triples the decoder should see; a monitor checks them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int PC_W       = 10;
    localparam int INSTR_W    = 9;
    localparam int START_ADDR = 0;
    localparam int LUT_DEPTH  = 16;
    localparam int ROM_N      = 1 << PC_W;

    typedef struct {
        int cyc;
        int pc;
        int instr;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;

    fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_DEPTH(LUT_DEPTH)) bus ();

    fetch_unit #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .START_ADDR(START_ADDR), .LUT_DEPTH(LUT_DEPTH)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read instruction ROM
    logic [INSTR_W-1:0] rom [ROM_N];
    always @(posedge Clk) bus.Imem_data <= rom[bus.Imem_addr];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];
    bit   mon_en   = 1'b0;
    bit   exp_done = 1'b0;

    // Reference model: phase 0 idle, 1 waiting for first word, 2 running,
    // 3 halted. m_pc is the address of the word on the ROM output.
    int   m_phase  = 0;
    int   m_pc     = 0;
    bit   m_bubble = 1'b0;
    int   m_tgt    = 0;
    bit   m_known  = 1'b0;
    int   m_lut [LUT_DEPTH];

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endfunction

    function automatic bit m_presenting();
        return (m_phase == 2) && !m_bubble;
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit stl, input bit br,
                              input int tgt, input bit hlt,
                              input bit lwe, input int lwa, input int lwd);
        bit v;
        int eff;
        v   = m_presenting();
        eff = tgt % ROM_N;
`ifdef BRANCH_LUT_EN
        eff = m_lut[tgt % LUT_DEPTH];
`endif
        if (rst) begin
            m_phase  = 0;
            m_pc     = START_ADDR;
            m_bubble = 1'b0;
            m_known  = 1'b1;
            for (int i = 0; i < LUT_DEPTH; i++) m_lut[i] = 0;
        end else begin
            case (m_phase)
                0, 3: if (st) begin
                    m_phase  = 1;
                    m_pc     = START_ADDR;
                    m_bubble = 1'b0;
                end
                1: if (!stl) m_phase = 2;
                default: if (!stl) begin
                    if (v && hlt) begin
                        m_phase = 3;
                    end else if (v && br) begin
                        m_pc     = (m_pc + 1) % ROM_N;
                        m_bubble = 1'b1;
                        m_tgt    = eff;
                    end else if (m_bubble) begin
                        m_pc     = m_tgt;
                        m_bubble = 1'b0;
                    end else begin
                        m_pc = (m_pc + 1) % ROM_N;
                    end
                end
            endcase
            if (lwe) m_lut[lwa % LUT_DEPTH] = lwd % ROM_N;
        end
    endtask

    task automatic tick(input bit rst, input bit st, input bit stl, input bit br,
                        input int tgt, input bit hlt,
                        input bit lwe, input int lwa, input int lwd);
        Reset             = rst;
        bus.Start         = st;
        bus.Stall         = stl;
        bus.Branch_en     = br;
        bus.Branch_target = PC_W'(tgt);
        bus.Halt_req      = hlt;
`ifdef BRANCH_LUT_EN
        bus.Lut_we        = lwe;
        bus.Lut_waddr     = 4'(lwa);
        bus.Lut_wdata     = PC_W'(lwd);
`endif
        mon_en = m_known;
        if (m_known) begin
            exp_done = (m_phase == 3);
            if (m_presenting()) q.push_back('{cyc, m_pc, int'(rom[m_pc])});
        end
        model_step(rst, st, stl, br, tgt, hlt, lwe, lwa, lwd);
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic t(input bit rst, input bit st, input bit stl, input bit br,
                     input int tgt, input bit hlt);
        tick(rst, st, stl, br, tgt, hlt, 1'b0, 0, 0);
    endtask

    // Idle cycles until the model says word p is being presented
    task automatic run_to(input int p);
        int n;
        n = 0;
        while (!(m_presenting() && m_pc == p) && n < 2000) begin
            t(0, 0, 0, 0, 0, 0);
            n++;
        end
        if (n >= 2000) chk("run_to_timeout", m_pc, p);
    endtask

    // Monitor: compare what the decoder sees against the scoreboard
    exp_t e;
    bit   exp_v;
    always @(negedge Clk) begin
        if (mon_en) begin
            chk("done", int'(bus.Done), int'(exp_done));
            exp_v = (q.size() > 0) && (q[0].cyc == cyc);
            chk("instr_valid", int'(bus.Instr_valid), int'(exp_v));
            if (exp_v) begin
                e = q.pop_front();
                if (bus.Instr_valid) begin
                    chk("pc", int'(bus.PC), e.pc);
                    chk("instruction", int'(bus.Instruction), e.instr);
                end
            end
            if (!bus.Instr_valid) chk("instr_zero_when_invalid", int'(bus.Instruction), 0);
        end
    end

    initial begin
        int c0;
        for (int i = 0; i < ROM_N; i++) rom[i] = INSTR_W'($urandom_range(0, (1 << INSTR_W) - 1));
        for (int i = 0; i < LUT_DEPTH; i++) m_lut[i] = 0;
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Stall = 1'b0; bus.Branch_en = 1'b0;
        bus.Branch_target = '0; bus.Halt_req = 1'b0;
`ifdef BRANCH_LUT_EN
        bus.Lut_we = 1'b0; bus.Lut_waddr = '0; bus.Lut_wdata = '0;
`endif

        // Reset state
        t(1, 0, 0, 0, 0, 0);
        t(1, 0, 0, 0, 0, 0);
        chk("rst_imem_addr", int'(bus.Imem_addr), START_ADDR);
        chk("rst_pc", int'(bus.PC), START_ADDR);
        chk("rst_valid", int'(bus.Instr_valid), 0);
        chk("rst_done", int'(bus.Done), 0);
        t(0, 0, 0, 0, 0, 0);

        // Start: fill cycle then sequential fetch
        t(0, 1, 0, 0, 0, 0);
        chk("fill_imem_addr", int'(bus.Imem_addr), START_ADDR);
        chk("fill_valid", int'(bus.Instr_valid), 0);
        t(0, 0, 0, 0, 0, 0);
        chk("first_pc", int'(bus.PC), START_ADDR);
        chk("first_imem_addr", int'(bus.Imem_addr), START_ADDR + 1);

        // Stall three cycles at PC 5
        run_to(5);
        repeat (3) t(0, 0, 1, 1, 3, 0);
        chk("stall_pc", int'(bus.PC), 5);

        // Branch at PC 7 to 0x20
        run_to(7);
        t(0, 0, 0, 1, 'h20, 0);
        chk("branch_bubble", int'(bus.Instr_valid), 0);
        t(0, 0, 0, 0, 0, 0);
        chk("branch_target_pc", int'(bus.PC), 'h20);

        // Halt together with branch at PC 9
        t(0, 0, 0, 1, 9, 0);
        run_to(9);
        t(0, 0, 0, 1, 'h100, 1);
        chk("halt_done", int'(bus.Done), 1);
        t(0, 0, 0, 1, 'h100, 1);
        chk("halt_pc_frozen", int'(bus.PC), 9);
        t(0, 1, 0, 0, 0, 0);
        t(0, 0, 0, 0, 0, 0);
        chk("restart_pc", int'(bus.PC), START_ADDR);
        chk("restart_valid", int'(bus.Instr_valid), 1);

        // Address wrap past 0x3FF
        t(0, 0, 0, 1, 'h3FE, 0);
        run_to('h3FF);
        chk("fpc_wrap", int'(bus.Imem_addr), 0);
        t(0, 0, 0, 0, 0, 0);
        chk("pc_wrap", int'(bus.PC), 0);

        // Reset at PC 0x3FF, asserted together with Start
        t(0, 0, 0, 1, 'h3FF, 0);
        run_to('h3FF);
        t(1, 1, 0, 0, 0, 0);
        chk("midrun_rst_pc", int'(bus.PC), START_ADDR);
        chk("midrun_rst_valid", int'(bus.Instr_valid), 0);
        t(0, 0, 0, 0, 0, 0);
        t(0, 0, 0, 0, 0, 0);
        chk("rst_beats_start", int'(bus.Imem_addr), START_ADDR);

`ifdef BRANCH_LUT_EN
        // LUT-sourced branch target
        tick(0, 1, 0, 0, 0, 0, 1'b1, 3, 'h155);
        run_to(2);
        t(0, 0, 0, 1, 3, 0);
        c0 = cyc;
        run_to('h155);
        chk("lut_branch_latency", cyc - c0, 1);
`else
        c0 = cyc;
`endif

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, ROM_N - 1)),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, LUT_DEPTH - 1)),
                 int'($urandom_range(0, ROM_N - 1)));
        end
        repeat (4) t(0, 0, 0, 0, 0, 0);
        chk("scoreboard_drained", q.size(), 0);
        if (c0 < 0) chk("cycle_count", c0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
